// File: rtl/sram_bus_bridge.sv
// Splits one 32-bit core load/store into one or two 16-bit SRAM frontend transactions.
// Optional sign extension of byte/half reads is enabled by defining SRAM_BRIDGE_SEXT_EN.
module sram_bus_bridge #(
  parameter int unsigned ALIGN_CHECK = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
`ifdef SRAM_BRIDGE_SEXT_EN
  input  logic        req_signed,
`endif
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        sram_valid,
  output logic        sram_rw,
  output logic [31:0] sram_addr,
  output logic [15:0] sram_dtw,
  input  logic [15:0] sram_dtr,
  input  logic        sram_done
);

  typedef enum logic [2:0] {StIdle, StIssue0, StWait0, StIssue1, StWait1, StResp} state_e;

  state_e      r_state;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [31:0] r_resp_rdata;
  logic        r_sram_valid;
  logic        r_sram_rw;
  logic [31:0] r_sram_addr;
  logic [15:0] r_sram_dtw;
  logic        r_rw;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [15:0] r_wdata_hi;
  logic [15:0] r_rdata_lo;
  logic        w_signed;
  logic        w_misalign;
  logic        w_err;
  logic [31:0] w_addr_al;
  logic [15:0] w_dtw0;
  logic [15:0] w_lo16;
  logic [31:0] w_ext;

`ifdef SRAM_BRIDGE_SEXT_EN
  logic        r_signed;
  assign w_signed = r_signed;
`else
  assign w_signed = 1'b0;
`endif

  assign w_misalign = (req_size == 2'b11) || ((req_size == 2'b01) && req_addr[0]) ||
                      ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
  assign w_err      = (ALIGN_CHECK != 0) && w_misalign;
  assign w_dtw0     = (req_size == 2'b00) ? {req_wdata[7:0], req_wdata[7:0]} : req_wdata[15:0];

  // With alignment checking off, sub-size address bits are dropped; size 11 acts as a word.
  always_comb begin
    w_addr_al = req_addr;
    case (req_size)
      2'b01:   w_addr_al = {req_addr[31:1], 1'b0};
      2'b10,
      2'b11:   w_addr_al = {req_addr[31:2], 2'b00};
      default: w_addr_al = req_addr;
    endcase
  end

  always_comb begin
    w_lo16 = sram_dtr;
    w_ext  = {16'h0000, sram_dtr};
    if (r_size == 2'b00) begin
      w_lo16 = {8'h00, (r_addr[0] ? sram_dtr[15:8] : sram_dtr[7:0])};
      w_ext  = {{24{w_signed & w_lo16[7]}}, w_lo16[7:0]};
    end else if (r_size == 2'b01) begin
      w_ext  = {{16{w_signed & w_lo16[15]}}, w_lo16};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'h0;
      r_sram_valid <= 1'b0;
      r_sram_rw    <= 1'b0;
      r_sram_addr  <= 32'h0;
      r_sram_dtw   <= 16'h0;
      r_rw         <= 1'b0;
      r_size       <= 2'b00;
      r_addr       <= 32'h0;
      r_wdata_hi   <= 16'h0;
      r_rdata_lo   <= 16'h0;
`ifdef SRAM_BRIDGE_SEXT_EN
      r_signed     <= 1'b0;
`endif
    end else begin
      case (r_state)
        StIdle: begin
          if (req_valid) begin
            r_rw         <= req_rw;
            r_size       <= req_size;
            r_addr       <= w_addr_al;
            r_wdata_hi   <= req_wdata[31:16];
            r_rdata_lo   <= 16'h0;
            r_resp_rdata <= 32'h0;
            r_req_ready  <= 1'b0;
`ifdef SRAM_BRIDGE_SEXT_EN
            r_signed     <= req_signed;
`endif
            if (w_err) begin
              r_state      <= StResp;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
            end else begin
              r_state      <= StIssue0;
              r_sram_valid <= 1'b1;
              r_sram_rw    <= req_rw;
              r_sram_addr  <= w_addr_al;
              r_sram_dtw   <= w_dtw0;
            end
          end
        end
        StIssue0: begin
          r_sram_valid <= 1'b0;
          r_state      <= StWait0;
        end
        StWait0: begin
          if (sram_done) begin
            r_rdata_lo <= w_lo16;
            if (r_size[1]) begin
              r_state      <= StIssue1;
              r_sram_valid <= 1'b1;
              r_sram_addr  <= r_addr + 32'd2;
              r_sram_dtw   <= r_wdata_hi;
            end else begin
              r_state      <= StResp;
              r_resp_valid <= 1'b1;
              r_resp_rdata <= r_rw ? 32'h0 : w_ext;
            end
          end
        end
        StIssue1: begin
          r_sram_valid <= 1'b0;
          r_state      <= StWait1;
        end
        StWait1: begin
          if (sram_done) begin
            r_state      <= StResp;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= r_rw ? 32'h0 : {sram_dtr, r_rdata_lo};
          end
        end
        StResp: begin
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_req_ready  <= 1'b1;
          r_state      <= StIdle;
        end
        default: begin
          r_state     <= StIdle;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;
  assign sram_valid = r_sram_valid;
  assign sram_rw    = r_sram_rw;
  assign sram_addr  = r_sram_addr;
  assign sram_dtw   = r_sram_dtw;

endmodule

// File: tb/tb_sram_bus_bridge.sv
// Directed bench for sram_bus_bridge: a 4-cycle frontend model serves both an
// aligned-checking instance and an ALIGN_CHECK=0 instance that share the request inputs.
module tb_sram_bus_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_rw = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
`ifdef SRAM_BRIDGE_SEXT_EN
  logic        req_signed = 1'b0;
`endif
  logic        sram_done = 1'b0;
  logic [15:0] sram_dtr = 16'h0;

  logic        req_ready, resp_valid, resp_err, sram_valid, sram_rw;
  logic [31:0] resp_rdata, sram_addr;
  logic [15:0] sram_dtw;
  logic        na_req_ready, na_resp_valid, na_resp_err, na_sram_valid, na_sram_rw;
  logic [31:0] na_resp_rdata, na_sram_addr;
  logic [15:0] na_sram_dtw;

  always #5 clk = ~clk;

  sram_bus_bridge #(.ALIGN_CHECK(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_rw(req_rw), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef SRAM_BRIDGE_SEXT_EN
    .req_signed(req_signed),
`endif
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .sram_valid(sram_valid), .sram_rw(sram_rw), .sram_addr(sram_addr),
    .sram_dtw(sram_dtw), .sram_dtr(sram_dtr), .sram_done(sram_done)
  );

  sram_bus_bridge #(.ALIGN_CHECK(0)) u_dut_na (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(na_req_ready),
    .req_rw(req_rw), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef SRAM_BRIDGE_SEXT_EN
    .req_signed(req_signed),
`endif
    .resp_valid(na_resp_valid), .resp_err(na_resp_err), .resp_rdata(na_resp_rdata),
    .sram_valid(na_sram_valid), .sram_rw(na_sram_rw), .sram_addr(na_sram_addr),
    .sram_dtw(na_sram_dtw), .sram_dtr(sram_dtr), .sram_done(sram_done)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Frontend model state; only the frontend process writes these.
  logic [15:0] fe_data [2];
  int          fe_cnt = 0;
  logic [31:0] fe_addr = 32'h0;
  int          n_pulse = 0;
  int          na_pulse = 0;
  logic [31:0] na_addr_log = 32'h0;
  logic [31:0] p_addr [64];
  logic [15:0] p_dtw [64];
  logic        p_rw [64];
  logic        prev_valid = 1'b0;
  int          viol = 0;
  int          n_resp = 0;
  int          stray_req = 0;
  int          stray_ack = 0;

  // Sampled on the falling edge; done is raised 4 cycles after the valid cycle.
  initial begin : frontend
    forever begin
      @(negedge clk);
      sram_done = 1'b0;
      if (resp_valid) n_resp++;
      if (sram_valid && (prev_valid || fe_cnt != 0)) viol++;
      prev_valid = sram_valid;
      if (sram_valid) begin
        if (n_pulse < 64) begin
          p_addr[n_pulse] = sram_addr;
          p_dtw[n_pulse]  = sram_dtw;
          p_rw[n_pulse]   = sram_rw;
        end
        n_pulse++;
      end
      if (na_sram_valid) begin
        na_pulse++;
        na_addr_log = na_sram_addr;
      end
      if (fe_cnt != 0) begin
        fe_cnt--;
        if (fe_cnt == 0) begin
          sram_done = 1'b1;
          sram_dtr  = fe_addr[1] ? fe_data[1] : fe_data[0];
        end
      end else if (sram_valid || na_sram_valid) begin
        fe_cnt  = 4;
        fe_addr = sram_valid ? sram_addr : na_sram_addr;
      end
      if (stray_req != stray_ack) begin
        stray_ack = stray_req;
        sram_done = 1'b1;
        sram_dtr  = 16'hDEAD;
      end
    end
  end

  // Called #1 after a rising edge while the bridge is idle.
  task automatic do_req(input logic rw, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, output int lat, output logic err,
                        output logic [31:0] rd);
    req_valid = 1'b1;
    req_rw    = rw;
    req_size  = sz;
    req_addr  = a;
    req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("ready_drop", 32'(req_ready), 32'd0);
    lat = 1;
    while (!resp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("resp_seen", 32'(resp_valid), 32'd1);
    err = resp_err;
    rd  = resp_rdata;
  endtask

  initial begin : stim
    int          lat;
    int          b;
    int          k;
    int          nr;
    logic        e;
    logic [31:0] rd;
    fe_data[0] = 16'h0;
    fe_data[1] = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_sram_valid", 32'(sram_valid), 32'd0);
    chk("rst_sram_rw", 32'(sram_rw), 32'd0);
    chk("rst_sram_addr", sram_addr, 32'h0);
    chk("rst_sram_dtw", 32'(sram_dtw), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Word read: low half first, then addr+2.
    fe_data[0] = 16'h5678; fe_data[1] = 16'h1234; b = n_pulse;
    do_req(1'b0, 2'b10, 32'h0000_0100, 32'h0, lat, e, rd);
    chk("wrd_npulse", n_pulse - b, 2);
    chk("wrd_addr0", p_addr[b], 32'h100);
    chk("wrd_addr1", p_addr[b+1], 32'h102);
    chk("wrd_rdata", rd, 32'h1234_5678);
    chk("wrd_lat", lat, 11);
    chk("wrd_err", 32'(e), 32'd0);
    @(posedge clk); #1;

    // Word write.
    b = n_pulse;
    do_req(1'b1, 2'b10, 32'h0000_0200, 32'hCAFE_BABE, lat, e, rd);
    chk("wwr_npulse", n_pulse - b, 2);
    chk("wwr_dtw0", 32'(p_dtw[b]), 32'h0000_BABE);
    chk("wwr_addr0", p_addr[b], 32'h200);
    chk("wwr_dtw1", 32'(p_dtw[b+1]), 32'h0000_CAFE);
    chk("wwr_addr1", p_addr[b+1], 32'h202);
    chk("wwr_rw", {30'h0, p_rw[b], p_rw[b+1]}, 32'h3);
    chk("wwr_rdata", rd, 32'h0);
    @(posedge clk); #1;

    // Byte read from the odd byte lane.
    fe_data[0] = 16'hA55A; fe_data[1] = 16'hA55A; b = n_pulse;
`ifdef SRAM_BRIDGE_SEXT_EN
    req_signed = 1'b1;
`endif
    do_req(1'b0, 2'b00, 32'h0000_0301, 32'h0, lat, e, rd);
`ifdef SRAM_BRIDGE_SEXT_EN
    req_signed = 1'b0;
    chk("brd_rdata", rd, 32'hFFFF_FFA5);
`else
    chk("brd_rdata", rd, 32'h0000_00A5);
`endif
    chk("brd_npulse", n_pulse - b, 1);
    chk("brd_addr", p_addr[b], 32'h301);
    chk("brd_lat", lat, 6);
    @(posedge clk); #1;

    // Byte write replicates the byte on both lanes.
    b = n_pulse;
    do_req(1'b1, 2'b00, 32'h0000_0300, 32'h0000_00EE, lat, e, rd);
    chk("bwr_npulse", n_pulse - b, 1);
    chk("bwr_dtw", 32'(p_dtw[b]), 32'h0000_EEEE);
    chk("bwr_lat", lat, 6);
    chk("bwr_rdata", rd, 32'h0);
    @(posedge clk); #1;

    // Aligned half read, zero-extended.
    fe_data[0] = 16'hBEEF; fe_data[1] = 16'hBEEF;
    do_req(1'b0, 2'b01, 32'h0000_0402, 32'h0, lat, e, rd);
    chk("hrd_rdata", rd, 32'h0000_BEEF);
    chk("hrd_lat", lat, 6);
    @(posedge clk); #1;

    // Misaligned half: rejected when checking, served at 0x400 when not.
    fe_data[0] = 16'h7E81; fe_data[1] = 16'h7E81; b = n_pulse; nr = na_pulse;
    do_req(1'b0, 2'b01, 32'h0000_0401, 32'h0, lat, e, rd);
    chk("mis_err", 32'(e), 32'd1);
    chk("mis_lat", lat, 1);
    chk("mis_rdata", rd, 32'h0);
    k = 0;
    while (!na_resp_valid && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk("mis_npulse", n_pulse - b, 0);
    chk("na_npulse", na_pulse - nr, 1);
    chk("na_resp", 32'(na_resp_valid), 32'd1);
    chk("na_err", 32'(na_resp_err), 32'd0);
    chk("na_addr", na_addr_log, 32'h400);
    chk("na_rdata", na_resp_rdata, 32'h0000_7E81);
    @(posedge clk); #1;

    // Reset during WAIT1 of a word read.
    fe_data[0] = 16'h1111; fe_data[1] = 16'h2222; b = n_pulse;
    req_valid = 1'b1; req_rw = 1'b0; req_size = 2'b10; req_addr = 32'h500;
    @(posedge clk); #1;
    req_valid = 1'b0;
    k = 0;
    while ((n_pulse - b) < 2 && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk("rst_reach_issue1", n_pulse - b, 2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mrst_ready", {30'h0, req_ready, na_req_ready}, 32'h3);
    chk("mrst_valids", {29'h0, resp_valid, sram_valid, na_sram_valid}, 32'h0);
    chk("mrst_rw", {30'h0, sram_rw, na_sram_rw}, 32'h0);
    chk("mrst_addr", sram_addr, 32'h0);
    chk("mrst_dtw", {sram_dtw, na_sram_dtw}, 32'h0);
    chk("mrst_rdata", resp_rdata, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    nr = n_resp;
    stray_req++;
    repeat (8) @(posedge clk);
    #1;
    chk("mrst_no_resp", n_resp - nr, 0);
    chk("mrst_idle_ready", 32'(req_ready), 32'd1);
    chk("mrst_no_issue", 32'(sram_valid), 32'd0);
    fe_data[0] = 16'h00C3; fe_data[1] = 16'h00C3;
    do_req(1'b0, 2'b00, 32'h0000_0600, 32'h0, lat, e, rd);
    chk("post_rst_rdata", rd, 32'h0000_00C3);
    chk("post_rst_lat", lat, 6);
    @(posedge clk); #1;

    // req_valid held through RESP is only taken in the following IDLE cycle.
    fe_data[0] = 16'h0042; fe_data[1] = 16'h0042;
    req_valid = 1'b1; req_rw = 1'b0; req_size = 2'b00; req_addr = 32'h700;
    @(posedge clk); #1;
    k = 0;
    while (!resp_valid && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk("hold_resp", 32'(resp_valid), 32'd1);
    chk("hold_resp_ready", 32'(req_ready), 32'd0);
    b = n_pulse;
    @(posedge clk); #1;
    chk("hold_idle_ready", 32'(req_ready), 32'd1);
    chk("hold_idle_noissue", 32'(sram_valid), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("hold_accept_issue", 32'(sram_valid), 32'd1);
    chk("hold_accept_ready", 32'(req_ready), 32'd0);
    k = 0;
    while (!resp_valid && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk("hold_second_resp", 32'(resp_valid), 32'd1);
    chk("hold_second_rdata", resp_rdata, 32'h0000_0042);
    chk("hold_npulse", n_pulse - b, 1);
    @(posedge clk); #1;

    chk("valid_protocol", viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sram_bus_bridge.md
Name: sram_bus_bridge

Overview:
- Upstream stage of the external SRAM frontend. Converts one 32-bit CPU load/store (byte, half or word) into one or two 16-bit SRAM frontend transactions.
- Drives the frontend's valid/rw/addr/write-data request interface and consumes its done/read-data response.
- Merges and extracts read data, then returns a single response to the core.

Parameters:
ALIGN_CHECK, 1, 1 = misaligned half/word requests are rejected with resp_err; 0 = address bits below the access size are ignored (forced to zero).

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  core request strobe
req_ready  output  1  bridge can accept a request (high only in IDLE)
req_rw  input  1  1 = write, 0 = read
req_size  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as misaligned/error)
req_addr  input  32  byte address
req_wdata  input  32  write data, right-aligned
resp_valid  output  1  one-cycle response pulse
resp_err  output  1  qualified by resp_valid; request rejected, no SRAM traffic
resp_rdata  output  32  read data, zero-extended; 0 for writes and errors
sram_valid  output  1  one-cycle pulse starting an SRAM frontend transaction
sram_rw  output  1  to frontend, 1 = write
sram_addr  output  32  byte address to frontend
sram_dtw  output  16  write halfword to frontend
sram_dtr  input  16  read halfword from frontend
sram_done  input  1  frontend completion pulse

Behaviour:
- Clock is clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - state IDLE
  - req_ready 1
  - resp_valid, resp_err, sram_valid, sram_rw 0
  - resp_rdata, sram_addr, sram_dtw 0
  - internal latches 0
- Handshake: accept on req_valid & req_ready. Latch rw, size, addr and wdata. req_ready drops the following cycle.
- Error check at accept, when ALIGN_CHECK=1: error if size 11, half with addr[0]=1, or word with addr[1:0]!=00. Error path goes IDLE -> RESP with resp_err=1, so resp_valid appears 1 cycle after accept.
- States:
  - IDLE: wait for request. sram_done seen here is ignored.
  - ISSUE0: sram_valid=1 for exactly this cycle. Drive:
    - sram_addr = latched addr
    - sram_rw = rw
    - sram_dtw = wdata[15:0], or for a byte write {wdata[7:0], wdata[7:0]}
    - Next state WAIT0.
  - WAIT0: sram_valid=0. sram_addr, sram_rw and sram_dtw are held stable. On sram_done, capture sram_dtr:
    - byte: rdata[7:0] = addr[0] ? dtr[15:8] : dtr[7:0]
    - half/word: rdata[15:0] = dtr
    - Next state ISSUE1 if word, else RESP.
  - ISSUE1: sram_valid=1 for one cycle, sram_addr = addr + 2, sram_dtw = wdata[31:16]. Next state WAIT1.
  - WAIT1: hold outputs. On sram_done, rdata[31:16] = dtr. Next state RESP.
  - RESP: resp_valid=1 for one cycle. resp_rdata = rdata for reads, 0 for writes. Next state IDLE, with req_ready=1 again in that cycle.
- Ordering: little-endian; the low halfword is always transferred first.
- sram_valid is never asserted in two consecutive cycles. It is never re-asserted before sram_done for the previous transaction.
- sram_done arriving in ISSUE0/ISSUE1 is illegal; the bridge ignores it.
- Correctness must not depend on frontend latency (any done delay of 1 or more cycles).
- Timing with the team's 4-state frontend (done 4 cycles after the valid cycle), accept at cycle 0:
  - byte/half: resp_valid at cycle 6
  - word: resp_valid at cycle 11
- resp_rdata is cleared to 0 at every accept.
- Reset mid-operation: return to IDLE immediately. Any in-flight frontend transaction is abandoned and its later sram_done is ignored in IDLE.

Optional Feature:
- Macro: SRAM_BRIDGE_SEXT_EN.
- Defined:
  - adds input port req_signed (1 bit), latched at accept
  - byte/half reads with req_signed=1 are sign-extended from bit 7 or 15 into resp_rdata
  - word reads and writes are unaffected
- Undefined: no port; all reads are zero-extended.

Test Plan:
- Reset release, then word read addr 0x00000100; frontend returns 0x5678 then 0x1234 -> sram_addr 0x100 then 0x102, exactly two sram_valid pulses, resp_rdata 0x12345678, resp_valid at cycle 11.
- Word write addr 0x00000200, wdata 0xCAFEBABE -> sram_dtw 0xBABE @0x200, then 0xCAFE @0x202, sram_rw=1, resp_rdata 0.
- Byte read addr 0x00000301, dtr 0xA55A -> single transaction at 0x301, resp_rdata 0x000000A5. With SRAM_BRIDGE_SEXT_EN and req_signed=1 -> 0xFFFFFFA5.
- Byte write addr 0x00000300, wdata 0x000000EE -> sram_dtw 0xEEEE, one transaction, resp_valid 6 cycles after accept.
- Half read addr 0x00000401, ALIGN_CHECK=1 -> no sram_valid, resp_valid+resp_err 1 cycle after accept; with ALIGN_CHECK=0 -> transaction at 0x400.
- Word read; assert rst_n low in WAIT1, release; inject stray sram_done -> outputs at reset values, no response, next request served normally; req_valid held high in RESP is accepted only in the following IDLE cycle.
